// File: rtl/score_digit_sequencer_pkg.sv
// rtl/score_digit_sequencer_pkg.sv - shared glyph geometry, BCD and FSM types for the score digit sequencer
package score_pkg;

    localparam int GLYPH_W      = 20;
    localparam int GLYPH_H      = 20;
    localparam int GLYPH_PIXELS = GLYPH_W * GLYPH_H;
    localparam int SCORE_W      = 14;

    typedef logic [3:0] bcd_nibble_t;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        COMMIT
    } bcd_state_t;

    // Double-dabble correction applied to a nibble before each shift.
    function automatic bcd_nibble_t dabble(input bcd_nibble_t n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

endpackage

// File: rtl/score_digit_sequencer_if.sv
// rtl/score_digit_sequencer_if.sv - raster, glyph ROM and pixel signals between the sequencer and the VGA side
interface score_digit_sequencer_if;

    logic [9:0] i_x;
    logic [9:0] i_y;
    logic       i_video_on;
    logic [3:0] o_sel;
    logic [9:0] o_numberaddr;
    logic [7:0] i_numberdata;
    logic [7:0] o_pixel;
    logic       o_pixel_valid;

    modport slave (
        input  i_x, i_y, i_video_on, i_numberdata,
        output o_sel, o_numberaddr, o_pixel, o_pixel_valid
    );

    modport master (
        output i_x, i_y, i_video_on, i_numberdata,
        input  o_sel, o_numberaddr, o_pixel, o_pixel_valid
    );

endinterface

// File: rtl/score_digit_sequencer_bin2bcd_seq.sv
// rtl/score_digit_sequencer_bin2bcd_seq.sv - sequential binary-to-BCD converter with one-deep pending load slot
module bin2bcd_seq
    import score_pkg::*;
#(
    parameter int DIGITS = 4
)(
    input  logic                i_clk2,
    input  logic                i_reset,
    input  logic [SCORE_W-1:0]  i_score,
    input  logic                i_score_load,
    output logic                o_busy,
    output logic [4*DIGITS-1:0] o_bcd
);

    localparam int BCD_W     = 4 * DIGITS;
    localparam int MAX_SCORE = (10 ** DIGITS) - 1;

    bcd_state_t         r_state, w_next;
    logic [SCORE_W-1:0] r_bin;
    logic [SCORE_W-1:0] r_pend_val;
    logic               r_pend;
    logic [BCD_W-1:0]   r_work;
    logic [BCD_W-1:0]   r_bcd;
    logic [BCD_W-1:0]   w_adj;
    logic [3:0]         r_cnt;

    function automatic logic [SCORE_W-1:0] saturate(input logic [SCORE_W-1:0] s);
        if (int'(s) > MAX_SCORE) return SCORE_W'(MAX_SCORE);
        return s;
    endfunction

    always_comb begin
        w_adj = '0;
        for (int k = 0; k < DIGITS; k++) w_adj[4*k +: 4] = dabble(r_work[4*k +: 4]);
    end

    always_ff @(posedge i_clk2) begin
        if (i_reset) r_state <= IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (i_score_load) w_next = CONVERT;
            CONVERT: if (r_cnt == 4'(SCORE_W - 1)) w_next = COMMIT;
            COMMIT:  w_next = (r_pend || i_score_load) ? CONVERT : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk2) begin
        if (i_reset) begin
            r_bin      <= '0;
            r_pend_val <= '0;
            r_pend     <= 1'b0;
            r_work     <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                IDLE: if (i_score_load) begin
                    r_bin  <= saturate(i_score);
                    r_work <= '0;
                    r_cnt  <= '0;
                end
                CONVERT: begin
                    r_work <= {w_adj[BCD_W-2:0], r_bin[SCORE_W-1]};
                    r_bin  <= r_bin << 1;
                    r_cnt  <= r_cnt + 4'd1;
                    if (i_score_load) begin
                        r_pend     <= 1'b1;
                        r_pend_val <= i_score;
                    end
                end
                COMMIT: begin
                    r_bcd  <= r_work;
                    r_work <= '0;
                    r_cnt  <= '0;
                    r_pend <= 1'b0;
                    // A load landing in this very cycle is newer than the pending slot.
                    if (i_score_load) r_bin <= saturate(i_score);
                    else if (r_pend)  r_bin <= saturate(r_pend_val);
                end
                default: ;
            endcase
        end
    end

    assign o_busy = (r_state != IDLE);
    assign o_bcd  = r_bcd;

endmodule

// File: rtl/score_digit_sequencer.sv
// rtl/score_digit_sequencer.sv - 3-stage score glyph render pipeline; LEADING_ZERO_BLANK_EN blanks leading zero digits
module score_digit_sequencer
    import score_pkg::*;
#(
    parameter int         ORIGIN_X    = 560,
    parameter int         ORIGIN_Y    = 16,
    parameter int         DIGITS      = 4,
    parameter logic [7:0] TRANSPARENT = 8'h00
)(
    input  logic               i_clk2,
    input  logic               i_reset,
    input  logic [SCORE_W-1:0] i_score,
    input  logic               i_score_load,
    output logic               o_busy,
    score_digit_sequencer_if.slave io_pix
);

    logic [4*DIGITS-1:0] w_bcd;
    logic [9:0]          w_dx, w_dy, w_lx, w_addr;
    logic [3:0]          w_digit, w_sel;
    logic                w_in_x, w_in_y, w_blank, w_hit;
    logic                r_hit1, r_hit2;

    bin2bcd_seq #(.DIGITS(DIGITS)) u_bcd (
        .i_clk2       (i_clk2),
        .i_reset      (i_reset),
        .i_score      (i_score),
        .i_score_load (i_score_load),
        .o_busy       (o_busy),
        .o_bcd        (w_bcd)
    );

    assign w_dx   = io_pix.i_x - 10'(ORIGIN_X);
    assign w_dy   = io_pix.i_y - 10'(ORIGIN_Y);
    assign w_in_x = (int'(io_pix.i_x) >= ORIGIN_X) && (int'(io_pix.i_x) < ORIGIN_X + GLYPH_W * DIGITS);
    assign w_in_y = (int'(io_pix.i_y) >= ORIGIN_Y) && (int'(io_pix.i_y) < ORIGIN_Y + GLYPH_H);

    // Digit index and in-glyph column via a compare chain; digit 0 is the most significant.
    always_comb begin
        w_digit = '0;
        w_lx    = w_dx;
        for (int k = 1; k < DIGITS; k++) begin
            if (w_dx >= 10'(GLYPH_W * k)) begin
                w_digit = 4'(k);
                w_lx    = w_dx - 10'(GLYPH_W * k);
            end
        end
    end

    always_comb begin
        w_sel = '0;
        for (int k = 0; k < DIGITS; k++)
            if (w_digit == 4'(k)) w_sel = w_bcd[4*(DIGITS-1-k) +: 4];
    end

    assign w_addr = (w_dy << 4) + (w_dy << 2) + w_lx;

`ifdef LEADING_ZERO_BLANK_EN
    logic w_lead_zero;
    always_comb begin
        w_lead_zero = 1'b1;
        w_blank     = 1'b0;
        for (int k = 0; k < DIGITS - 1; k++) begin
            w_lead_zero = w_lead_zero && (w_bcd[4*(DIGITS-1-k) +: 4] == 4'd0);
            if (w_digit == 4'(k) && w_lead_zero) w_blank = 1'b1;
        end
    end
`else
    assign w_blank = 1'b0;
`endif

    assign w_hit = io_pix.i_video_on && w_in_x && w_in_y && !w_blank;

    always_ff @(posedge i_clk2) begin
        if (i_reset) begin
            r_hit1               <= 1'b0;
            r_hit2               <= 1'b0;
            io_pix.o_sel         <= '0;
            io_pix.o_numberaddr  <= '0;
            io_pix.o_pixel       <= '0;
            io_pix.o_pixel_valid <= 1'b0;
        end else begin
            r_hit1 <= w_hit;
            if (w_hit) begin
                io_pix.o_sel        <= w_sel;
                io_pix.o_numberaddr <= w_addr;
            end
            r_hit2               <= r_hit1;
            io_pix.o_pixel_valid <= r_hit2 && (io_pix.i_numberdata != TRANSPARENT);
            io_pix.o_pixel       <= (r_hit2 && (io_pix.i_numberdata != TRANSPARENT)) ? io_pix.i_numberdata : 8'h00;
        end
    end

endmodule
